seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_if.sv | 21 ++
 rtl/seg7_scan.sv | 111 +++++++++++
 tb/tb_seg7_scan.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Display-scanner bus: the BCD/decimal-point request from the register side and
// the multiplexed anode/segment drive toward the 4-digit display.
interface seg7_scan_if;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output bcd_in, dp_in, blank_lz,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner. Each digit owns DIGIT_CYCLES clocks;
// the first output cycle of every slot is forced dark to stop ghosting between
// anodes. A snapshot of the digits is taken at frame start so a frame never
// mixes old and new values. Optional leading-zero blanking.
module seg7_scan #(
  parameter int DIGIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      sh_bcd;
  logic [3:0]       sh_dp;
  logic             slot_last;
  logic             frame_start;
  logic [3:0]       digit;
  logic [3:0]       blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // Hex to segments, gfedcba, active-high.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign slot_last      = (cnt == CNT_LAST);
  assign frame_start    = (cnt == '0) && (idx == 2'd0);
  assign bus.frame_done = slot_last && (idx == 2'd3);
  assign digit          = sh_bcd[{idx, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows so a zero value still displays "0".
  assign blank[3] = bus.blank_lz && (sh_bcd[15:12] == 4'h0);
  assign blank[2] = blank[3] && (sh_bcd[11:8] == 4'h0);
  assign blank[1] = blank[2] && (sh_bcd[7:4] == 4'h0);
  assign blank[0] = 1'b0;

  // Next display drive: dark on the first cycle of a slot or for a blanked digit.
  always_comb begin
    an_next  = 4'hF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if ((cnt != '0) && !blank[idx]) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = ~hex_decode(digit);
      dp_next  = ~sh_dp[idx];
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame snapshot of the digits and decimal points.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_bcd <= 16'h0000;
      sh_dp  <= 4'h0;
    end else if (frame_start) begin
      sh_bcd <= bus.bcd_in;
      sh_dp  <= bus.dp_in;
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.an  <= 4'hF;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_next;
      bus.seg <= seg_next;
      bus.dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a 4-cycle digit slot (16-cycle frame).
module tb_seg7_scan;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  seg7_scan_if bus ();

  seg7_scan #(.DIGIT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, ".an"}, {12'h0, bus.an}, 16'h000F);
    check({tag, ".seg"}, {9'h0, bus.seg}, 16'h007F);
    check({tag, ".dp"}, {15'h0, bus.dp}, 16'h0001);
    check({tag, ".fd"}, {15'h0, bus.frame_done}, 16'h0000);
  endtask

  // Runs n_edges clocks starting at a frame-start edge. Slot k shows digit k;
  // an_t/seg_t/dp_t hold the hand-derived per-slot drive (slot 0 in the LSBs).
  // At edge chg_at the bcd input is switched to chg_bcd after sampling.
  task automatic run_frame(input string tag, input int n_edges,
                           input logic [15:0] an_t, input logic [27:0] seg_t,
                           input logic [3:0] dp_t, input int chg_at,
                           input logic [15:0] chg_bcd);
    int slot;
    int sub;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
    for (int j = 1; j <= n_edges; j++) begin
      @(posedge clk);
      @(negedge clk);
      slot  = (j - 1) / 4;
      sub   = (j - 1) % 4;
      e_an  = (sub == 0) ? 4'hF  : an_t[slot*4 +: 4];
      e_seg = (sub == 0) ? 7'h7F : seg_t[slot*7 +: 7];
      e_dp  = (sub == 0) ? 1'b1  : dp_t[slot];
      e_fd  = (j == 15);
      check($sformatf("%s.an[%0d]", tag, j), {12'h0, bus.an}, {12'h0, e_an});
      check($sformatf("%s.seg[%0d]", tag, j), {9'h0, bus.seg}, {9'h0, e_seg});
      check($sformatf("%s.dp[%0d]", tag, j), {15'h0, bus.dp}, {15'h0, e_dp});
      check($sformatf("%s.fd[%0d]", tag, j), {15'h0, bus.frame_done}, {15'h0, e_fd});
      if (j == chg_at) bus.bcd_in = chg_bcd;
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    clk          = 1'b0;
    reset        = 1'b1;
    bus.bcd_in   = 16'h1234;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;

    // Reset state, and nothing moves while reset is held.
    #2;
    check_dark("rst0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark($sformatf("rst_hold%0d", i));
    end
    reset = 1'b0;

    // 1234, no blanking: two frames to show the 16-cycle frame_done period.
    run_frame("f1234a", 16, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 0, 16'h0);
    run_frame("f1234b", 16, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 0, 16'h0);

    // 0050 with leading-zero blanking: digits 3 and 2 dark.
    bus.bcd_in   = 16'h0050;
    bus.blank_lz = 1'b1;
    run_frame("f0050", 16, {4'hF, 4'hF, 4'hD, 4'hE},
              {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 0, 16'h0);

    // 0000 blanked with a dp request on digit 3: blanked digit keeps dp off.
    bus.bcd_in = 16'h0000;
    bus.dp_in  = 4'b1000;
    run_frame("f0000", 16, {4'hF, 4'hF, 4'hF, 4'hE},
              {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 0, 16'h0);

    // 8888 with dp on digits 0 and 2.
    bus.bcd_in   = 16'h8888;
    bus.dp_in    = 4'b0101;
    bus.blank_lz = 1'b0;
    run_frame("f8888", 16, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1010, 0, 16'h0);

    // AAAA switched to BBBB during digit 1: current frame keeps A.
    bus.bcd_in = 16'hAAAA;
    bus.dp_in  = 4'h0;
    run_frame("fAAAA", 16, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h08, 7'h08, 7'h08, 7'h08}, 4'hF, 5, 16'hBBBB);
    run_frame("fBBBB", 16, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h03, 7'h03, 7'h03, 7'h03}, 4'hF, 0, 16'h0);

    // Reset mid-frame at idx=2, cnt=2: outputs go dark without a clock.
    bus.bcd_in = 16'h1234;
    run_frame("fpre", 10, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 0, 16'h0);
    #2;
    reset = 1'b1;
    #1;
    check_dark("rst_async");
    bus.bcd_in = 16'h5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_dark($sformatf("rst_mid%0d", i));
    end
    bus.bcd_in = 16'h1234;
    reset = 1'b0;
    run_frame("fpost", 16, {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
